memory_store_merge: RTL and testbench
=====================================

# memory_store_merge

Store-side counterpart of the load-data extraction path. Accepts one MIPS store per handshake (SB, SH, SW, SWL, SWR). It aligns the register data onto big-endian byte lanes and builds a byte mask. Partial-word stores are then written to a word-wide data memory through a read-modify-write sequence. Sits in the MEM stage between the EX/MEM pipeline register and the data memory port.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  block idle, can accept a store
- st_op  in  6  instruction opcode field IR[31:26]
- st_addr  in  32  byte address
- st_data  in  32  rt register value
- done  out  1  one-cycle pulse, store completed
- err  out  1  one-cycle pulse, store rejected (misaligned or non-store opcode)
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address, {st_addr[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ack on a read
- mem_ack  in  1  access complete; ignored while mem_req=0
- mem_be  out  4  byte write enables, be[3]=bits 31:24 (only with STORE_BYTE_WRITE_EN)

## Operation
- Lanes are big-endian. Offset k = st_addr[1:0]. Byte k maps to bits 31-8k..24-8k.
- Alignment and mask are computed from the value latched at accept:
  - SB 101000: data = {4{rt[7:0]}}, mask = lane k.
  - SH 101001: data = {2{rt[15:0]}}, mask = lanes k,k+1. k must be 0 or 2.
  - SW 101011: data = rt, mask = 1111. k must be 0.
  - SWL 101010: data = rt >> 8k, mask = lanes k..3.
  - SWR 101110: data = rt << 8(3-k), mask = lanes 0..k.
- Merged word: wdata = (aligned & maskbits) | (rdata & ~maskbits), where maskbits expands each mask bit to 8 bits.
- FSM states and transitions:
  - IDLE: st_ready=1. On st_valid, latch the request.
    - Misaligned or non-store opcode → ERR.
    - mask=1111 → WR.
    - Otherwise → RD.
  - RD: mem_req=1, mem_we=0. On mem_ack, capture the merge with mem_rdata → WR.
  - WR: mem_req=1, mem_we=1. mem_wdata is held stable. On mem_ack → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - ERR: err=1 for one cycle, no memory access → IDLE.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable until mem_ack.
- st_ready=0 in every state except IDLE. st_valid is ignored while st_ready=0.
- Reset values: st_ready=1, done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, state=IDLE.
- Reset mid-operation aborts the access immediately and discards the pending store.

## Timing
- Accept in cycle T. First mem_req in cycle T+1.
- Partial store with zero-wait memory (ack in the same cycle as req):
  - RD in T+1, WR in T+2, done in T+3, st_ready=1 in T+4.
- Full word: WR in T+1, done in T+2.
- Error: err in T+1, st_ready=1 in T+2.
- Each mem wait cycle adds exactly one cycle. No minimum pulse width is required on mem_ack.

## Configuration
- STORE_BYTE_WRITE_EN defined:
  - mem_be port present.
  - RD state never entered; every accepted store goes IDLE→WR.
  - mem_wdata = aligned data, mem_be = mask.
- Undefined:
  - mem_be absent.
  - Partial stores use RMW as above.

## Structure
- Shared package memory_store_pkg holds:
  - opcode constants OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR
  - FSM state enum (IDLE, RD, WR, DONE, ERR)
- Sub-module store_lane_align: combinational.
  - Inputs: op, offset, rt.
  - Outputs: aligned data, 4-bit mask, misaligned/illegal flag.
- The FSM, latching and merge logic live in the top module.

## Test plan
- SB, addr 0x1001, rt=0x000000AB, mem_rdata=0x11223344, zero-wait → one read, then write 0x11AB3344 to addr 0x1000, done in T+3.
- SW, addr 0x2000, rt=0xDEADBEEF → no read, write 0xDEADBEEF, done in T+2. SW at 0x2002 → err in T+1, mem_req never asserted.
- SWL offset 1, rt=0xAABBCCDD, rdata=0x11223344 → write 0x11AABBCC. SWR offset 1, same values → write 0xCCDD3344.
- SH at 0x3002, rt=0x0000BEEF, rdata=0x11223344, mem_ack delayed 3 cycles on each access → write 0x1122BEEF. Request signals are held stable throughout, and st_valid pulses during busy are ignored.
- Reset asserted during RD wait → all outputs at reset values immediately, st_ready=1 after release, no write issued.
- With STORE_BYTE_WRITE_EN, SB addr 0x1003, rt=0x55 → single write, mem_wdata=0x55555555, mem_be=0001.

Source files
------------

// File: rtl/memory_store_pkg.sv
// Shared opcode constants, FSM state type and mask helper for the store merge path.
package memory_store_pkg;

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SWR = 6'b101110;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StDone,
        StErr
    } store_state_e;

    // mask[i] covers bits 8i+7:8i, so mask[3] is big-endian byte lane 0.
    function automatic logic [31:0] expand_mask(input logic [3:0] mask);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational big-endian lane alignment and byte mask for MIPS stores.
module store_lane_align
    import memory_store_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rt,
    output logic [31:0] o_data,
    output logic [3:0]  o_mask,
    output logic        o_bad
);

    always_comb begin
        o_data = '0;
        o_mask = '0;
        o_bad  = 1'b0;
        case (i_op)
            OP_SB: begin
                o_data = {4{i_rt[7:0]}};
                o_mask = 4'b1000 >> i_offset;
            end
            OP_SH: begin
                o_data = {2{i_rt[15:0]}};
                o_mask = i_offset[1] ? 4'b0011 : 4'b1100;
                o_bad  = i_offset[0];
            end
            OP_SW: begin
                o_data = i_rt;
                o_mask = 4'b1111;
                o_bad  = |i_offset;
            end
            OP_SWL: begin
                o_data = i_rt >> {i_offset, 3'b000};
                o_mask = 4'b1111 >> i_offset;
            end
            OP_SWR: begin
                o_data = i_rt << {~i_offset, 3'b000};
                o_mask = 4'b1111 << ~i_offset;
            end
            default: o_bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/memory_store_merge.sv
// MEM-stage store unit: aligns store data and writes it via read-modify-write.
// Define STORE_BYTE_WRITE_EN to use byte enables (mem_be) instead of RMW.
module memory_store_merge
    import memory_store_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [5:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef STORE_BYTE_WRITE_EN
    ,
    output logic [3:0]  mem_be
`endif
);

    logic [31:0]  w_aligned;
    logic [3:0]   w_mask;
    logic         w_bad;

    store_state_e r_state;
    logic         r_st_ready;
    logic         r_done;
    logic         r_err;
    logic         r_mem_req;
    logic         r_mem_we;
    logic [31:0]  r_mem_addr;
    logic [31:0]  r_mem_wdata;

    store_lane_align u_align (
        .i_op     (st_op),
        .i_offset (st_addr[1:0]),
        .i_rt     (st_data),
        .o_data   (w_aligned),
        .o_mask   (w_mask),
        .o_bad    (w_bad)
    );

`ifdef STORE_BYTE_WRITE_EN
    logic [3:0] r_mem_be;
    logic       w_unused_rdata;

    assign w_unused_rdata = ^mem_rdata;
    assign mem_be         = r_mem_be;
`else
    logic [31:0] r_data;
    logic [3:0]  r_mask;
    logic [31:0] w_mask_bits;

    assign w_mask_bits = expand_mask(r_mask);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_st_ready  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef STORE_BYTE_WRITE_EN
            r_mem_be    <= '0;
`else
            r_data      <= '0;
            r_mask      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (st_valid) begin
                        r_st_ready <= 1'b0;
                        if (w_bad) begin
                            r_state <= StErr;
                            r_err   <= 1'b1;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= {st_addr[31:2], 2'b00};
                            r_mem_wdata <= w_aligned;
`ifdef STORE_BYTE_WRITE_EN
                            r_mem_be    <= w_mask;
                            r_mem_we    <= 1'b1;
                            r_state     <= StWr;
`else
                            r_data      <= w_aligned;
                            r_mask      <= w_mask;
                            // Full-word stores skip the read; aligned data is already final.
                            if (&w_mask) begin
                                r_mem_we <= 1'b1;
                                r_state  <= StWr;
                            end else begin
                                r_mem_we <= 1'b0;
                                r_state  <= StRd;
                            end
`endif
                        end
                    end
                end
`ifndef STORE_BYTE_WRITE_EN
                StRd: begin
                    if (mem_ack) begin
                        r_mem_wdata <= (r_data & w_mask_bits) | (mem_rdata & ~w_mask_bits);
                        r_mem_we    <= 1'b1;
                        r_state     <= StWr;
                    end
                end
`endif
                StWr: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= StDone;
`ifdef STORE_BYTE_WRITE_EN
                        r_mem_be  <= '0;
`endif
                    end
                end
                StDone, StErr: begin
                    r_st_ready <= 1'b1;
                    r_state    <= StIdle;
                end
                default: begin
                    r_st_ready <= 1'b1;
                    r_mem_req  <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

    assign st_ready  = r_st_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_memory_store_merge.sv
// Scoreboard bench for memory_store_merge: byte-level store model, randomized memory latency.
// Build with STORE_BYTE_WRITE_EN defined to exercise the byte-enable variant.
module tb_memory_store_merge;

    localparam bit [5:0] T_SB  = 6'b101000;
    localparam bit [5:0] T_SH  = 6'b101001;
    localparam bit [5:0] T_SW  = 6'b101011;
    localparam bit [5:0] T_SWL = 6'b101010;
    localparam bit [5:0] T_SWR = 6'b101110;

`ifdef STORE_BYTE_WRITE_EN
    localparam bit BE_MODE = 1'b1;
`else
    localparam bit BE_MODE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [5:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef STORE_BYTE_WRITE_EN
    logic [3:0]  mem_be;
`endif

    memory_store_merge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef STORE_BYTE_WRITE_EN
        ,
        .mem_be    (mem_be)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit        is_err;
        int        n_rd;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [3:0]  be;
        int        t_acc;
        int        base;
    } exp_t;

    exp_t      sb_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    bit [31:0] ref_mem [bit [31:0]];
    bit [31:0] dut_mem [bit [31:0]];

    // Responder-observed activity for the store in flight
    int        fixed_wait = 0;
    int        waits = 0, rd_cnt = 0, wr_cnt = 0, req_seen = 0, total_wr = 0;
    bit [31:0] wr_addr, wr_data;
    bit [3:0]  wr_be;
    bit        chk_ready_next = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit [31:0] init_word(input bit [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
    endfunction

    function automatic bit [31:0] rd_ref(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic bit [31:0] rd_dut(input bit [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : init_word(a);
    endfunction

    function automatic bit [31:0] be_bits(input bit [3:0] be);
        bit [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return r;
    endfunction

    task automatic preset(input bit [31:0] a, input bit [31:0] v);
        ref_mem[a] = v;
        dut_mem[a] = v;
    endtask

    // MIPS store semantics on individual bytes; lane 0 is the most significant byte.
    task automatic model(input bit [5:0] op, input bit [31:0] addr, input bit [31:0] rt,
                         output exp_t e, output bit [31:0] new_word);
        bit [7:0]  b[4];
        bit [7:0]  r[4];
        bit [3:0]  touched = 4'b0;
        bit        legal = 1'b1;
        int        k = int'(addr[1:0]);
        bit [31:0] wa = {addr[31:2], 2'b00};
        bit [31:0] old = rd_ref(wa);
        for (int i = 0; i < 4; i++) begin
            b[i] = old[31-8*i -: 8];
            r[i] = rt[31-8*i -: 8];
        end
        case (op)
            T_SB: begin b[k] = r[3]; touched[3-k] = 1'b1; end
            T_SH: begin
                if (k % 2 != 0) legal = 1'b0;
                else begin
                    b[k] = r[2]; b[k+1] = r[3];
                    touched[3-k] = 1'b1; touched[2-k] = 1'b1;
                end
            end
            T_SW: begin
                if (k != 0) legal = 1'b0;
                else for (int i = 0; i < 4; i++) begin b[i] = r[i]; touched[3-i] = 1'b1; end
            end
            T_SWL: for (int i = 0; i <= 3 - k; i++) begin
                b[k+i] = r[i]; touched[3-(k+i)] = 1'b1;
            end
            T_SWR: for (int j = 0; j <= k; j++) begin
                b[k-j] = r[3-j]; touched[3-(k-j)] = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        new_word = {b[0], b[1], b[2], b[3]};
        e.is_err = !legal;
        e.n_rd   = (legal && touched != 4'hF && !BE_MODE) ? 1 : 0;
        e.addr   = wa;
        e.wdata  = new_word;
        e.be     = touched;
        e.t_acc  = 0;
        e.base   = !legal ? 1 : (e.n_rd != 0 ? 3 : 2);
    endtask

    task automatic issue(input bit [5:0] op, input bit [31:0] addr, input bit [31:0] rt,
                         input bit apply);
        exp_t      e;
        bit [31:0] nw;
        int        guard = 0;
        model(op, addr, rt, e, nw);
        @(negedge clk);
        while (!st_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!st_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got st_ready=0 expected 1 within 500 cycles");
            return;
        end
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = rt;
        e.t_acc  = cyc;
        sb_q.push_back(e);
        if (apply && !e.is_err) ref_mem[e.addr] = nw;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_op    = 6'($urandom);
        st_addr  = $urandom;
        st_data  = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb_q.size() != 0 || !st_ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Memory responder: programmable ack latency, also checks request stability while waiting.
    initial begin
        int        wleft = -1;
        bit        pend = 1'b0;
        bit [31:0] h_addr, h_wdata;
        bit        h_we;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0;
                wleft   = -1;
                pend    = 1'b0;
                continue;
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                req_seen++;
                if (pend) begin
                    chk("hold_addr", mem_addr, h_addr);
                    chk("hold_we", 32'(mem_we), 32'(h_we));
                    chk("hold_wdata", mem_wdata, h_wdata);
                end
                if (wleft < 0) wleft = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
                if (wleft == 0) begin
                    mem_ack = 1'b1;
                    pend    = 1'b0;
                    wleft   = -1;
                    if (mem_we) begin
                        wr_cnt++;
                        total_wr++;
                        wr_addr = mem_addr;
                        wr_data = mem_wdata;
`ifdef STORE_BYTE_WRITE_EN
                        wr_be = mem_be;
                        dut_mem[mem_addr] = (rd_dut(mem_addr) & ~be_bits(mem_be))
                                          | (mem_wdata & be_bits(mem_be));
`else
                        wr_be = 4'hF;
                        dut_mem[mem_addr] = mem_wdata;
`endif
                    end else begin
                        rd_cnt++;
                        mem_rdata = rd_dut(mem_addr);
                    end
                end else begin
                    wleft--;
                    waits++;
                    pend    = 1'b1;
                    h_addr  = mem_addr;
                    h_we    = mem_we;
                    h_wdata = mem_wdata;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every done/err pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_ready_next = 1'b0;
                continue;
            end
            if (chk_ready_next) begin
                chk("ready_after_completion", 32'(st_ready), 32'd1);
                chk_ready_next = 1'b0;
            end
            if (done || err) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: got done=%0b err=%0b expected none",
                             done, err);
                end else begin
                    e = sb_q.pop_front();
                    chk("kind_err", 32'(err), 32'(e.is_err));
                    chk("kind_done", 32'(done), 32'(!e.is_err));
                    chk("ready_low_at_completion", 32'(st_ready), 32'd0);
                    chk("latency", 32'(cyc), 32'(e.t_acc + e.base + waits));
                    chk("read_count", 32'(rd_cnt), 32'(e.n_rd));
                    if (e.is_err) begin
                        chk("err_no_req", 32'(req_seen) | 32'(mem_req), 32'd0);
                        chk("err_no_write", 32'(wr_cnt), 32'd0);
                    end else begin
                        chk("write_count", 32'(wr_cnt), 32'd1);
                        chk("wr_addr", wr_addr, e.addr);
                        if (BE_MODE) begin
                            chk("wr_be", 32'(wr_be), 32'(e.be));
                            chk("wr_data_masked", wr_data & be_bits(wr_be),
                                e.wdata & be_bits(e.be));
                        end else begin
                            chk("wr_data", wr_data, e.wdata);
                        end
                    end
                end
                waits = 0; rd_cnt = 0; wr_cnt = 0; req_seen = 0;
                chk_ready_next = 1'b1;
            end
        end
    end

    initial begin
        bit [5:0] ops[5] = '{T_SB, T_SH, T_SW, T_SWL, T_SWR};
        bit [5:0] op;
        int       snap;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_op    = '0;
        st_addr  = '0;
        st_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
`ifdef STORE_BYTE_WRITE_EN
        chk("rst_be", 32'(mem_be), 32'd0);
`endif
        rst_n = 1'b1;

        fixed_wait = 0;
        preset(32'h1000, 32'h11223344);
        issue(T_SB, 32'h0000_1001, 32'h0000_00AB, 1'b1);
        drain();
        if (!BE_MODE) chk("tp_sb_word", wr_data, 32'h11AB3344);

        issue(T_SW, 32'h0000_2000, 32'hDEADBEEF, 1'b1);
        drain();
        chk("tp_sw_word", wr_data, 32'hDEADBEEF);
        issue(T_SW, 32'h0000_2002, 32'h1234_5678, 1'b1);
        drain();

        preset(32'h4000, 32'h11223344);
        preset(32'h4004, 32'h11223344);
        issue(T_SWL, 32'h0000_4001, 32'hAABBCCDD, 1'b1);
        drain();
        if (!BE_MODE) chk("tp_swl_word", wr_data, 32'h11AABBCC);
        issue(T_SWR, 32'h0000_4005, 32'hAABBCCDD, 1'b1);
        drain();
        if (!BE_MODE) chk("tp_swr_word", wr_data, 32'hCCDD3344);

        // Delayed acks plus st_valid pulses while busy.
        fixed_wait = 3;
        preset(32'h3000, 32'h11223344);
        issue(T_SH, 32'h0000_3002, 32'h0000_BEEF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            st_valid = (i % 2 == 0);
            st_op    = T_SW;
            st_addr  = 32'h0000_3000;
            st_data  = 32'h0BAD_0BAD;
        end
        @(negedge clk);
        st_valid = 1'b0;
        drain();
        if (!BE_MODE) chk("tp_sh_word", wr_data, 32'h1122BEEF);

`ifdef STORE_BYTE_WRITE_EN
        fixed_wait = 0;
        issue(T_SB, 32'h0000_1003, 32'h0000_0055, 1'b1);
        drain();
        chk("tp_be_wdata", wr_data, 32'h55555555);
        chk("tp_be_mask", 32'(wr_be), 32'h1);
`else
        // Reset while the read is still waiting for its ack.
        fixed_wait = 20;
        preset(32'h6000, 32'hCAFEF00D);
        issue(T_SB, 32'h0000_6002, 32'h0000_0077, 1'b0);
        repeat (3) @(negedge clk);
        snap  = total_wr;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(st_ready), 32'd1);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        chk("abort_done_err", 32'({done, err}), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waits = 0; rd_cnt = 0; wr_cnt = 0; req_seen = 0;
        fixed_wait = 0;
        @(negedge clk);
        chk("post_abort_ready", 32'(st_ready), 32'd1);
        chk("post_abort_no_write", 32'(total_wr), 32'(snap));
        issue(T_SB, 32'h0000_6001, 32'h0000_0099, 1'b1);
        drain();
        chk("post_abort_word", wr_data, 32'hCA99F00D);
`endif

        fixed_wait = -1;
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 4)];
            issue(op, 32'h0000_5000 + 32'($urandom_range(0, 63)), $urandom, 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
